column_mac_cacc: RTL and testbench
==================================

Name: column_mac_cacc

Overview:
- Channel accumulator directly downstream of the column-systolic MAC array.
- Takes the Tout-lane partial sums the array emits once per output-width position. Accumulates them across all input-channel-chunk/kernel-tap passes in an on-chip position buffer.
- On the final pass, emits one completed Tout-lane result per position to the post-processing (quant/activation) stage.

Parameters:
- TOUT, 32, output-channel lanes per beat
- IN_DW, 20, signed partial-sum width per lane (MAX_DW2+base_log2Tin)
- ACC_DW, 32, signed accumulator width per lane
- OUT_DW, 24, signed output width per lane; ACC_DW >= OUT_DW >= IN_DW
- WOUT_MAX, 64, max positions per tile (power of 2)
- AW, 6, log2(WOUT_MAX)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg, begins tile
- cfg_wout_num  in  AW+1  positions per pass, 1..WOUT_MAX
- cfg_loop_num  in  16  accumulation passes, 1..65535
- in_vld  in  1  partial-sum beat valid (no backpressure)
- in_dat  in  TOUT*IN_DW  lane i at [i*IN_DW+:IN_DW], signed
- out_vld  out  1  result beat valid
- out_dat  out  TOUT*OUT_DW  lane i at [i*OUT_DW+:OUT_DW], signed
- out_pos  out  AW  position index of out_dat
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse with the final out_vld
- err  out  1  sticky: in_vld outside RUN; cleared by start

Behaviour:
- Reset is synchronous active-low on clk only. All outputs, counters and pipeline valids reset to 0; FSM resets to IDLE.
- Buffer RAM is not reset; contents are don't-care because pass 0 overwrites.
- FSM states:
  - IDLE: start -> RUN; latch cfg; clear pos_cnt, loop_cnt and err.
  - RUN: each in_vld is accepted unconditionally. pos_cnt increments and wraps at cfg_wout_num-1; at wrap, loop_cnt increments. The beat with loop_cnt==cfg_loop_num-1 and pos_cnt==cfg_wout_num-1 moves the FSM to DRAIN.
  - DRAIN: wait until pipeline empty (2 cycles) -> IDLE.
- Flags per beat: first = (loop_cnt==0); last = (loop_cnt==cfg_loop_num-1). cfg_loop_num==1 sets both flags on every beat.
- Pipeline, beat accepted in cycle T:
  - Edge ending T: capture beat, flags and address into s1; issue synchronous RAM read (read-first).
  - Cycle T+1: per lane, sum = sext(in) if first, else acc_old + sext(in), in ACC_DW two's complement, wrapping.
  - Edge ending T+1: write sum to RAM and capture into s2.
- out_vld is high in T+2 only for last beats; otherwise s2 updates the buffer silently. Latency from in_vld to out_vld is 2 cycles.
- Hazard: when s2 valid and s2 address == s1 address (back-to-back beats with cfg_wout_num==1), acc_old takes s2's sum, not RAM read data. No other hazard exists.
- done is asserted with the last out_vld; busy drops the cycle after done.
- start while busy is ignored.
- in_vld in IDLE or DRAIN is dropped and sets err.
- rst_n low mid-tile aborts immediately; no out_vld or done follows.
- Narrowing when not saturating: out_dat lane = sum[OUT_DW-1:0].

Optional Feature:
- CACC_SAT_EN defined: each output lane saturates signed to OUT_DW, clamping to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1]. The internal accumulator remains ACC_DW, wrapping.
- Not defined: plain truncation to OUT_DW bits; no saturation logic.

Decomposition:
- Shared package holds: TOUT, IN_DW, ACC_DW, OUT_DW, WOUT_MAX, AW, the FSM state encoding (IDLE/RUN/DRAIN), and the lane-slice width constants.
- One natural sub-module, cacc_pos_ram: simple dual-port RAM, WOUT_MAX x TOUT*ACC_DW, sync read-first, one write port. Isolates technology-specific memory inference.
- Lane adders and saturation stay inline in generate loops.

Test Plan:
- wout=4, loop=3, every lane in_dat=+5 on all 12 beats back-to-back -> exactly 4 out_vld. out_pos 0,1,2,3; every lane 15; done with pos 3; first out_vld 2 cycles after beat 9.
- wout=1, loop=4, back-to-back beats 1,2,3,4 on lane 0 (forwarding) -> single out_vld with lane 0 = 10, out_pos 0.
- wout=2, loop=2, in_vld gaps of 0-3 random cycles, lane 7 values -100,+30,-1,+50 -> out_pos 0 = -101, out_pos 1 = 80.
- CACC_SAT_EN, OUT_DW=24, loop=2, lane 0 = 2^19-1 twice with ACC_DW sum exceeding... (use loop=40 to exceed 2^23-1) -> out 8388607. Without the macro -> truncated low 24 bits.
- in_vld pulse in IDLE -> err=1, no out_vld. Next start clears err.
- rst_n low for 1 cycle after 3 of 8 beats (wout=4, loop=2) -> busy=0 and outputs 0 next cycle. A fresh tile then produces correct sums despite stale RAM contents.

Source files
------------

// File: rtl/column_mac_cacc_pkg.sv
// column_mac_cacc_pkg: shared widths and FSM encoding for the channel accumulator
package column_mac_cacc_pkg;
  localparam int TOUT = 32;
  localparam int IN_DW = 20;
  localparam int ACC_DW = 32;
  localparam int OUT_DW = 24;
  localparam int WOUT_MAX = 64;
  localparam int AW = 6;
  localparam int IN_W = TOUT * IN_DW;
  localparam int ACC_W = TOUT * ACC_DW;
  localparam int OUT_W = TOUT * OUT_DW;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/cacc_pos_ram.sv
// cacc_pos_ram: WOUT_MAX x TOUT*ACC_DW simple dual-port RAM, sync read-first
module cacc_pos_ram
  import column_mac_cacc_pkg::*;
(
  input  logic             clk,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [ACC_W-1:0] rd,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [ACC_W-1:0] wd
);
  logic [ACC_W-1:0] mem [WOUT_MAX];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/column_mac_cacc.sv
// column_mac_cacc: per-position channel accumulator after the MAC array; CACC_SAT_EN enables signed output saturation
module column_mac_cacc
  import column_mac_cacc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW:0]      cfg_wout_num,
  input  logic [15:0]      cfg_loop_num,
  input  logic             in_vld,
  input  logic [IN_W-1:0]  in_dat,
  output logic             out_vld,
  output logic [OUT_W-1:0] out_dat,
  output logic [AW-1:0]    out_pos,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t state, state_nx;
  logic [AW:0] wout_r;
  logic [15:0] loop_r, loop_cnt;
  logic [AW-1:0] pos_cnt;
  logic acc_in, pos_end, loop_end, fin;
  logic s1_vld, s1_first, s1_last, s1_fin;
  logic [AW-1:0] s1_addr;
  logic [IN_W-1:0] s1_dat;
  logic s2_vld, s2_last, s2_fin;
  logic [AW-1:0] s2_addr;
  logic [ACC_W-1:0] s2_sum, rd_dat, acc_old, sum;
  assign acc_in = in_vld && state == RUN;
  assign pos_end = {1'b0, pos_cnt} == wout_r - (AW+1)'(1);
  assign loop_end = loop_cnt == loop_r - 16'd1;
  assign fin = acc_in && pos_end && loop_end;
  assign busy = state != IDLE;
  assign out_vld = s2_vld && s2_last;
  assign done = s2_vld && s2_fin;
  assign out_pos = s2_addr;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (fin ? DRAIN : RUN) :
               (done ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wout_r <= '0;
      loop_r <= '0;
      pos_cnt <= '0;
      loop_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        wout_r <= cfg_wout_num;
        loop_r <= cfg_loop_num;
        pos_cnt <= '0;
        loop_cnt <= '0;
        err <= 1'b0;
      end else begin
        err <= err | (in_vld && state != RUN);
        if (acc_in) begin
          pos_cnt <= pos_end ? '0 : pos_cnt + AW'(1);
          loop_cnt <= pos_end ? loop_cnt + 16'd1 : loop_cnt;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      s1_fin <= 1'b0;
      s1_addr <= '0;
      s1_dat <= '0;
      s2_vld <= 1'b0;
      s2_last <= 1'b0;
      s2_fin <= 1'b0;
      s2_addr <= '0;
      s2_sum <= '0;
    end else begin
      s1_vld <= acc_in;
      if (acc_in) begin
        s1_first <= loop_cnt == 16'd0;
        s1_last <= loop_end;
        s1_fin <= fin;
        s1_addr <= pos_cnt;
        s1_dat <= in_dat;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_last <= s1_last;
        s2_fin <= s1_fin;
        s2_addr <= s1_addr;
        s2_sum <= sum;
      end
    end
  end
  cacc_pos_ram u_ram (
    .clk(clk),
    .re (acc_in),
    .ra (pos_cnt),
    .rd (rd_dat),
    .we (s1_vld),
    .wa (s1_addr),
    .wd (sum)
  );
  assign acc_old = (s2_vld && s2_addr == s1_addr) ? s2_sum : rd_dat;
  for (genvar i = 0; i < TOUT; i++) begin : g_lane
    logic [ACC_DW-1:0] ext;
    assign ext = {{(ACC_DW-IN_DW){s1_dat[i*IN_DW+IN_DW-1]}}, s1_dat[i*IN_DW+:IN_DW]};
    assign sum[i*ACC_DW+:ACC_DW] = s1_first ? ext : acc_old[i*ACC_DW+:ACC_DW] + ext;
`ifdef CACC_SAT_EN
    logic [ACC_DW-1:0] a;
    logic fits;
    assign a = s2_sum[i*ACC_DW+:ACC_DW];
    assign fits = (&a[ACC_DW-1:OUT_DW-1]) || !(|a[ACC_DW-1:OUT_DW-1]);
    assign out_dat[i*OUT_DW+:OUT_DW] = fits ? a[OUT_DW-1:0] :
                                       a[ACC_DW-1] ? {1'b1, {(OUT_DW-1){1'b0}}} :
                                       {1'b0, {(OUT_DW-1){1'b1}}};
`else
    assign out_dat[i*OUT_DW+:OUT_DW] = s2_sum[i*ACC_DW+:OUT_DW];
`endif
  end
endmodule

// File: tb/tb_column_mac_cacc.sv
// tb_column_mac_cacc: scoreboard bench for column_mac_cacc (honours CACC_SAT_EN)
module tb_column_mac_cacc;
  import column_mac_cacc_pkg::*;
  typedef struct {
    logic [OUT_W-1:0] dat;
    logic [AW-1:0] pos;
    logic fin;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_vld = 1'b0;
  logic [AW:0] cfg_wout_num = '0;
  logic [15:0] cfg_loop_num = '0;
  logic [IN_W-1:0] in_dat = '0;
  logic out_vld, busy, done, err;
  logic [OUT_W-1:0] out_dat;
  logic [AW-1:0] out_pos;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  exp_t q[$];
  int acc[WOUT_MAX][TOUT];
  int m_pos, m_loop, m_wout, m_ln;
  column_mac_cacc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_wout_num(cfg_wout_num),
    .cfg_loop_num(cfg_loop_num), .in_vld(in_vld), .in_dat(in_dat),
    .out_vld(out_vld), .out_dat(out_dat), .out_pos(out_pos),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_vld) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: out_vld=1 pos=%0d, want no output", out_pos);
      end else begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (out_dat !== e.dat) begin
          miscompares++;
          for (int i = 0; i < TOUT; i++)
            if (out_dat[i*OUT_DW+:OUT_DW] !== e.dat[i*OUT_DW+:OUT_DW]) begin
              $display("FAIL out_dat pos %0d lane %0d: got %0d want %0d", e.pos, i,
                       $signed(out_dat[i*OUT_DW+:OUT_DW]), $signed(e.dat[i*OUT_DW+:OUT_DW]));
              break;
            end
        end
        vectors++;
        if (out_pos !== e.pos) begin
          miscompares++;
          $display("FAIL out_pos: got %0d want %0d", out_pos, e.pos);
        end
        vectors++;
        if (done !== e.fin) begin
          miscompares++;
          $display("FAIL done pos %0d: got %0b want %0b", e.pos, done, e.fin);
        end
        vectors++;
        if (cyc !== e.cyc) begin
          miscompares++;
          $display("FAIL latency pos %0d: out at cycle %0d want %0d", e.pos, cyc, e.cyc);
        end
      end
    end else if (done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_alone: done=1 with out_vld=0, want 0");
    end
  end
  function automatic logic [OUT_DW-1:0] narrow(int a);
`ifdef CACC_SAT_EN
    int mx = (1 << (OUT_DW-1)) - 1;
    int mn = -(1 << (OUT_DW-1));
    int c = a > mx ? mx : a < mn ? mn : a;
    return c[OUT_DW-1:0];
`else
    return a[OUT_DW-1:0];
`endif
  endfunction
  function automatic logic [IN_W-1:0] fill(int v);
    logic [IN_W-1:0] d;
    for (int i = 0; i < TOUT; i++) d[i*IN_DW+:IN_DW] = v[IN_DW-1:0];
    return d;
  endfunction
  function automatic logic [IN_W-1:0] lane_dat(int lane, int v);
    logic [IN_W-1:0] d = '0;
    d[lane*IN_DW+:IN_DW] = v[IN_DW-1:0];
    return d;
  endfunction
  function automatic logic [IN_W-1:0] rnd(int r);
    logic [IN_W-1:0] d;
    for (int i = 0; i < TOUT; i++) begin
      int v = int'($urandom_range(2*r)) - r;
      d[i*IN_DW+:IN_DW] = v[IN_DW-1:0];
    end
    return d;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(int w, int l);
    in_vld = 1'b0;
    start = 1'b1;
    cfg_wout_num = (AW+1)'(w);
    cfg_loop_num = 16'(l);
    tick();
    start = 1'b0;
    m_pos = 0;
    m_loop = 0;
    m_wout = w;
    m_ln = l;
  endtask
  task automatic beat(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] e;
    logic signed [IN_DW-1:0] t;
    for (int i = 0; i < TOUT; i++) begin
      t = d[i*IN_DW+:IN_DW];
      acc[m_pos][i] = (m_loop == 0) ? int'(t) : acc[m_pos][i] + int'(t);
      e[i*OUT_DW+:OUT_DW] = narrow(acc[m_pos][i]);
    end
    if (m_loop == m_ln - 1)
      q.push_back('{e, AW'(m_pos), (m_pos == m_wout - 1), cyc + 2});
    if (m_pos == m_wout - 1) begin
      m_pos = 0;
      m_loop++;
    end else m_pos++;
    in_vld = 1'b1;
    in_dat = d;
    tick();
  endtask
  task automatic idle(int n);
    in_vld = 1'b0;
    repeat (n) tick();
  endtask
  task automatic finish_tile(string name);
    int k = 0;
    in_vld = 1'b0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, want 0", name, k);
    end
    tick();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing: %0d results outstanding, want 0", name, q.size());
    end
    q.delete();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({busy, out_vld, done, err} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy/out_vld/done/err=%b want 0000", {busy, out_vld, done, err});
    end
    vectors++;
    if (out_dat !== '0 || out_pos !== '0) begin
      miscompares++;
      $display("FAIL reset_out: out_pos=%0d out_dat nonzero=%0b want 0/0", out_pos, |out_dat);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
  endtask
  task automatic test_basic();
    do_start(4, 3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %0b want 1", busy);
    end
    for (int k = 0; k < 12; k++) beat(fill(5));
    finish_tile("basic");
  endtask
  task automatic test_forward();
    do_start(1, 4);
    for (int k = 1; k <= 4; k++) beat(lane_dat(0, k));
    finish_tile("forward");
  endtask
  task automatic test_gaps();
    int vals[4] = '{-100, 30, -1, 50};
    do_start(2, 2);
    for (int k = 0; k < 4; k++) begin
      beat(lane_dat(7, vals[k]));
      idle($urandom_range(3));
      if (k == 1) begin
        start = 1'b1;
        cfg_wout_num = (AW+1)'(1);
        cfg_loop_num = 16'd1;
        tick();
        start = 1'b0;
      end
    end
    finish_tile("gaps");
  endtask
  task automatic test_sat();
    logic [IN_W-1:0] d = lane_dat(2, -7);
    d[0+:IN_DW] = 20'h7FFFF;
    d[IN_DW+:IN_DW] = 20'h80000;
    do_start(1, 40);
    for (int k = 0; k < 40; k++) beat(d);
    finish_tile("sat");
  endtask
  task automatic test_err();
    idle(1);
    in_vld = 1'b1;
    in_dat = fill(9);
    tick();
    idle(4);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got %0b want 1", err);
    end
    do_start(1, 1);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %0b want 0", err);
    end
    beat(rnd(1000));
    finish_tile("err");
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_stay: got %0b want 0", err);
    end
  endtask
  task automatic test_abort();
    do_start(4, 2);
    for (int k = 0; k < 3; k++) beat(rnd(50000));
    in_vld = 1'b0;
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({busy, out_vld, done} !== 3'b0 || out_dat !== '0) begin
      miscompares++;
      $display("FAIL abort_out: busy/out_vld/done=%b dat nonzero=%0b want 000/0",
               {busy, out_vld, done}, |out_dat);
    end
    rst_n = 1'b1;
    idle(4);
    do_start(4, 2);
    for (int k = 0; k < 8; k++) beat(rnd(50000));
    finish_tile("abort");
  endtask
  task automatic test_back_to_back();
    do_start(64, 2);
    for (int k = 0; k < 128; k++) beat(rnd(200000));
    finish_tile("full");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_gaps();
    test_sat();
    test_err();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
